// File: rtl/quantum_state_prob_seq_pkg.sv
// Shared constants for the measurement-probability engine.
//   TOTAL_BITS : default width of one signed fixed-point word
//   FX_BITS    : default number of fractional bits (1.0 = 1 << FX_BITS)
//   S_*        : FSM state encodings for the top-level sequencer
package quantum_state_prob_seq_pkg;

  localparam int TOTAL_BITS = 16;
  localparam int FX_BITS    = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/qsm_mag_sq_pipe.sv
// Two-stage saturating |a|^2 for one complex fixed-point amplitude.
//   clk, rst_n : clock, asynchronous active-low reset
//   v_in       : amplitude valid on re/im this cycle
//   re, im     : signed real / imaginary parts
//   v_out      : mag_sq valid (two cycles after v_in)
//   mag_sq     : re^2 + im^2 in the same fixed-point format, saturated positive
module qsm_mag_sq_pipe
  import quantum_state_prob_seq_pkg::*;
#(
  parameter int DW  = TOTAL_BITS,
  parameter int FXW = FX_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 v_in,
  input  logic signed [DW-1:0] re,
  input  logic signed [DW-1:0] im,
  output logic                 v_out,
  output logic        [DW-1:0] mag_sq
);

  localparam logic signed [2*DW-1:0] MAX_W = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic        [DW:0]     MAX_S = {2'b00, {(DW-1){1'b1}}};

  // Sign-extend before squaring so the full 2*DW product is kept.
  logic signed [2*DW-1:0] w_re_ext, w_im_ext, w_re_sq, w_im_sq;
  logic        [DW-1:0]   w_re_sat, w_im_sat;
  logic        [DW:0]     w_sum;

  assign w_re_ext = {{DW{re[DW-1]}}, re};
  assign w_im_ext = {{DW{im[DW-1]}}, im};
  assign w_re_sq  = (w_re_ext * w_re_ext) >>> FXW;
  assign w_im_sq  = (w_im_ext * w_im_ext) >>> FXW;
  // Squares are never negative, so only the positive limit matters.
  assign w_re_sat = (w_re_sq > MAX_W) ? MAX_W[DW-1:0] : w_re_sq[DW-1:0];
  assign w_im_sat = (w_im_sq > MAX_W) ? MAX_W[DW-1:0] : w_im_sq[DW-1:0];

  logic          r_v1, r_v2;
  logic [DW-1:0] r_re2, r_im2, r_mag;

  assign w_sum = {1'b0, r_re2} + {1'b0, r_im2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_re2 <= '0;
      r_im2 <= '0;
      r_mag <= '0;
    end else begin
      r_v1  <= v_in;
      r_re2 <= w_re_sat;
      r_im2 <= w_im_sat;
      r_v2  <= r_v1;
      r_mag <= (w_sum > MAX_S) ? MAX_S[DW-1:0] : w_sum[DW-1:0];
    end
  end

  assign v_out  = r_v2;
  assign mag_sq = r_mag;

endmodule

// File: rtl/quantum_state_prob_seq.sv
// Sequential measurement-probability engine for an N-qubit state vector.
// Accepts one vector per handshake, streams the NS = 2**N_QUBITS amplitudes
// through a shared |a|^2 pipe, and reports per-state probabilities, their
// saturated total and the index of the largest probability.
// Optional build macro: QSM_NORM_CHECK_EN enables the normalisation flag.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake (ready only in IDLE)
//   q_state_in           : {amp_0..amp_NS-1}, amp_0 in MSBs, amp = {re, im}
//   out_valid / out_ready: result handshake, results held until accepted
//   mag_sq_out           : {p_0..p_NS-1}, p_0 in MSBs
//   prob_sum, max_idx    : saturated total, argmax (lowest index wins ties)
//   busy                 : engine not in IDLE
//   norm_err             : |prob_sum - 1.0| > NORM_TOL, qualified by out_valid
module quantum_state_prob_seq
  import quantum_state_prob_seq_pkg::*;
#(
  parameter int N_QUBITS = 2,
  parameter int DW       = TOTAL_BITS,
  parameter int FXW      = FX_BITS,
  parameter int NORM_TOL = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [2*DW*(1<<N_QUBITS)-1:0]  q_state_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DW*(1<<N_QUBITS)-1:0]    mag_sq_out,
  output logic [DW-1:0]                  prob_sum,
  output logic [N_QUBITS-1:0]            max_idx,
  output logic                           busy,
  output logic                           norm_err
);

  localparam int            NS   = 1 << N_QUBITS;
  localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
  localparam logic [N_QUBITS-1:0] LAST = N_QUBITS'(NS - 1);

  logic [1:0]          r_state;
  logic [N_QUBITS-1:0] r_idx, r_widx, r_max_idx;
  logic                r_drain, r_norm_err;
  logic signed [DW-1:0] r_re [NS];
  logic signed [DW-1:0] r_im [NS];
  logic [DW-1:0]       r_slot [NS];
  logic [DW-1:0]       r_sum, r_max_val;

  logic          w_accept, w_v_out;
  logic [DW-1:0] w_mag, w_sum_add, w_sum_next;
  logic [DW:0]   w_sum_ext;

  assign w_accept = in_valid && (r_state == S_IDLE);

  qsm_mag_sq_pipe #(.DW(DW), .FXW(FXW)) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .v_in   (r_state == S_RUN),
    .re     (r_re[r_idx]),
    .im     (r_im[r_idx]),
    .v_out  (w_v_out),
    .mag_sq (w_mag)
  );

  assign w_sum_ext  = {1'b0, r_sum} + {1'b0, w_mag};
  assign w_sum_add  = (w_sum_ext > {1'b0, MAXV}) ? MAXV : w_sum_ext[DW-1:0];
  // Total including the sample landing this cycle; the last sample lands on
  // the same edge that enters DONE, so the norm check must see it.
  assign w_sum_next = w_v_out ? w_sum_add : r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_widx    <= '0;
      r_drain   <= 1'b0;
      r_sum     <= '0;
      r_max_val <= '0;
      r_max_idx <= '0;
      for (int k = 0; k < NS; k++) begin
        r_re[k]   <= '0;
        r_im[k]   <= '0;
        r_slot[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          for (int k = 0; k < NS; k++) begin
            r_re[k]   <= q_state_in[(NS-1-k)*2*DW + DW +: DW];
            r_im[k]   <= q_state_in[(NS-1-k)*2*DW +: DW];
            r_slot[k] <= '0;
          end
          r_idx     <= '0;
          r_widx    <= '0;
          r_sum     <= '0;
          r_max_val <= '0;
          r_max_idx <= '0;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            r_drain <= 1'b0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_drain <= 1'b1;
          if (r_drain) r_state <= S_DONE;
        end
        default: if (out_ready) r_state <= S_IDLE;
      endcase

      // Write-back runs independently of the state; results trail issue by 2.
      if (w_v_out) begin
        r_slot[r_widx] <= w_mag;
        r_widx         <= r_widx + 1'b1;
        r_sum          <= w_sum_add;
        if (w_mag > r_max_val) begin
          r_max_val <= w_mag;
          r_max_idx <= r_widx;
        end
      end
    end
  end

`ifdef QSM_NORM_CHECK_EN
  localparam logic signed [DW+1:0] ONE_S = (DW+2)'(1 << FXW);
  logic signed [DW+1:0] w_diff;
  logic                 w_norm_bad;
  assign w_diff     = $signed({2'b00, w_sum_next}) - ONE_S;
  assign w_norm_bad = ((w_diff < 0) ? -w_diff : w_diff) > (DW+2)'(NORM_TOL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_norm_err <= 1'b0;
    else if (w_accept)                      r_norm_err <= 1'b0;
    else if (r_state == S_DRAIN && r_drain) r_norm_err <= w_norm_bad;
  end
`else
  localparam int NORM_TOL_UNUSED = NORM_TOL;
  assign r_norm_err = 1'b0;
`endif

  generate
    for (genvar k = 0; k < NS; k++) begin : g_out
      assign mag_sq_out[(NS-1-k)*DW +: DW] = r_slot[k];
    end
  endgenerate

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign prob_sum  = r_sum;
  assign max_idx   = r_max_idx;
  assign norm_err  = r_norm_err;

endmodule

// File: tb/tb_quantum_state_prob_seq.sv
module tb_quantum_state_prob_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, out_ready;
  logic [127:0] q;
  logic in_ready, out_valid, busy, norm_err;
  logic [63:0] mag;
  logic [15:0] sum;
  logic [1:0]  mx;

  logic in_valid3, out_ready3;
  logic [255:0] q3;
  logic in_ready3, out_valid3, busy3, norm_err3;
  logic [127:0] mag3;
  logic [15:0]  sum3;
  logic [2:0]   mx3;

  int pass_cnt = 0;
  int total    = 0;

`ifdef QSM_NORM_CHECK_EN
  localparam logic NE_SAT = 1'b1, NE_ZERO = 1'b1;
`else
  localparam logic NE_SAT = 1'b0, NE_ZERO = 1'b0;
`endif

  quantum_state_prob_seq #(.N_QUBITS(2), .DW(16), .FXW(8), .NORM_TOL(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .q_state_in(q), .out_valid(out_valid), .out_ready(out_ready),
    .mag_sq_out(mag), .prob_sum(sum), .max_idx(mx), .busy(busy), .norm_err(norm_err));

  quantum_state_prob_seq #(.N_QUBITS(3), .DW(16), .FXW(8), .NORM_TOL(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .q_state_in(q3), .out_valid(out_valid3), .out_ready(out_ready3),
    .mag_sq_out(mag3), .prob_sum(sum3), .max_idx(mx3), .busy(busy3), .norm_err(norm_err3));

  // amp = {re, im}; amp_0 in MSBs
  localparam logic [127:0] V_SUPER = {16'sd128, 16'sd0, 16'sd128, 16'sd0,
                                      16'sd128, 16'sd0, 16'sd128, 16'sd0};
  localparam logic [127:0] V_BASIS = {32'd0, 32'd0, 16'sd256, 16'sd0, 32'd0};
  localparam logic [127:0] V_SAT   = {-16'sd128, -16'sd128, 16'h7FFF, 16'h7FFF, 32'd0, 32'd0};
  localparam logic [63:0]  P_SUPER = {16'd64, 16'd64, 16'd64, 16'd64};
  localparam logic [63:0]  P_BASIS = {16'd0, 16'd0, 16'd256, 16'd0};
  localparam logic [63:0]  P_SAT   = {16'd128, 16'h7FFF, 16'd0, 16'd0};

  task automatic send(input logic [127:0] v);
    @(negedge clk);
    q = v; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen (20 = timed out).
  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic consume();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; q = V_SUPER; out_ready = 1'b0;
    in_valid3 = 1'b0; out_ready3 = 1'b0; q3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({out_valid, busy, in_ready, norm_err} !== 4'b0010)
      $display("FAIL reset_ctrl got %b want 0010", {out_valid, busy, in_ready, norm_err});
    else pass_cnt++;
    total++; if ({mag, sum, mx} !== '0)
      $display("FAIL reset_data got %h/%h/%0d want 0", mag, sum, mx);
    else pass_cnt++;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || in_ready3 !== 1'b1)
      $display("FAIL reset_idle busy=%b rdy3=%b want 0/1", busy, in_ready3);
    else pass_cnt++;
  endtask

  task automatic test_superposition();
    int lat;
    send(V_SUPER);
    total++; if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL super_busy busy=%b rdy=%b want 1/0", busy, in_ready);
    else pass_cnt++;
    wait_out(lat);
    total++; if (lat != 6) $display("FAIL super_latency got %0d want 6", lat); else pass_cnt++;
    total++; if (mag !== P_SUPER) $display("FAIL super_mag got %h want %h", mag, P_SUPER); else pass_cnt++;
    total++; if (sum !== 16'd256 || mx !== 2'd0 || norm_err !== 1'b0)
      $display("FAIL super_sum got %0d/%0d/%b want 256/0/0", sum, mx, norm_err);
    else pass_cnt++;
    consume();
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL super_release rdy=%b ov=%b want 1/0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_basis();
    int lat;
    send(V_BASIS);
    wait_out(lat);
    total++; if (lat != 6) $display("FAIL basis_latency got %0d want 6", lat); else pass_cnt++;
    total++; if (mag !== P_BASIS) $display("FAIL basis_mag got %h want %h", mag, P_BASIS); else pass_cnt++;
    total++; if (sum !== 16'd256 || mx !== 2'd2 || norm_err !== 1'b0)
      $display("FAIL basis_sum got %0d/%0d/%b want 256/2/0", sum, mx, norm_err);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_saturation();
    int lat;
    send(V_SAT);
    wait_out(lat);
    total++; if (mag !== P_SAT) $display("FAIL sat_mag got %h want %h", mag, P_SAT); else pass_cnt++;
    total++; if (sum !== 16'h7FFF || mx !== 2'd1)
      $display("FAIL sat_sum got %h/%0d want 7fff/1", sum, mx);
    else pass_cnt++;
    total++; if (norm_err !== NE_SAT)
      $display("FAIL sat_norm got %b want %b", norm_err, NE_SAT);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad = 0;
    send(V_SUPER);
    wait_out(lat);
    q = V_BASIS; in_valid = 1'b1;   // offered while DONE; must wait
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || mag !== P_SUPER || sum !== 16'd256) bad++;
    end
    total++; if (bad != 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad); else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release rdy=%b ov=%b want 1/0", in_ready, out_valid);
    else pass_cnt++;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(lat);
    total++; if (lat != 6) $display("FAIL bp_latency got %0d want 6", lat); else pass_cnt++;
    total++; if (mag !== P_BASIS || mx !== 2'd2)
      $display("FAIL bp_next got %h/%0d want %h/2", mag, mx, P_BASIS);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    send(V_BASIS);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if ({out_valid, busy, in_ready} !== 3'b001 || {mag, sum, mx} !== '0)
      $display("FAIL abort_state ctrl=%b data=%h/%h/%0d want 001/0", {out_valid, busy, in_ready}, mag, sum, mx);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    send(V_SUPER);
    wait_out(lat);
    total++; if (lat != 6 || mag !== P_SUPER || sum !== 16'd256 || mx !== 2'd0)
      $display("FAIL abort_recover lat=%0d mag=%h sum=%0d mx=%0d want 6/%h/256/0", lat, mag, sum, mx, P_SUPER);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_nq3_zero();
    int lat = 0;
    @(negedge clk);
    q3 = '0; in_valid3 = 1'b1;
    @(posedge clk);
    #1 in_valid3 = 1'b0;
    while (lat < 30) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (out_valid3) break;
    end
    total++; if (lat != 10) $display("FAIL nq3_latency got %0d want 10", lat); else pass_cnt++;
    total++; if (mag3 !== '0 || sum3 !== 16'd0 || mx3 !== 3'd0)
      $display("FAIL nq3_data got %h/%0d/%0d want 0", mag3, sum3, mx3);
    else pass_cnt++;
    total++; if (norm_err3 !== NE_ZERO)
      $display("FAIL nq3_norm got %b want %b", norm_err3, NE_ZERO);
    else pass_cnt++;
    @(negedge clk); out_ready3 = 1'b1;
    @(posedge clk);
    #1 out_ready3 = 1'b0;
    @(negedge clk);
    total++; if (in_ready3 !== 1'b1) $display("FAIL nq3_release rdy=%b want 1", in_ready3); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_superposition();
    test_basis();
    test_saturation();
    test_back_to_back();
    test_reset_mid_run();
    test_nq3_zero();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
